// File: rtl/matrix_multiply_core3x3_feeder.sv
// rtl/matrix_multiply_core3x3_feeder.sv - writer side of the 3x3 matrix-multiply core input
// Register-bus coefficient shadows, commit-driven coefficient load, buffered ADC sample stream.
module matrix_multiply_core3x3_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic        system1000,
  input  logic        system1000_rstn,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_ack,
  output logic        sys_err,
  input  logic [15:0] adc_a,
  input  logic [15:0] adc_b,
  input  logic [15:0] adc_c,
  input  logic        adc_valid,
  output logic [69:0] arg
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_STREAM, ST_LOAD} state_e;

  state_e           state_q;
  logic [3:0]       idx_q;
  logic [15:0]      coef_q [9];
  logic [47:0]      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [PW:0]      count_q;
  logic             pending_q, enable_q;
  logic [CNT_W-1:0] commit_cnt_q, ovf_cnt_q;
  logic [69:0]      arg_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             ack_q, err_q, err_d;

  logic [3:0] reg_sel;
  logic       busy, commit_wr, enter_load, fifo_empty, fifo_full, pop, push, drop;
  logic       unused_bits;

  assign reg_sel     = sys_addr[5:2];
  assign busy        = (state_q == ST_LOAD);
  assign commit_wr   = sys_wen && (reg_sel == 4'd9) && sys_wdata[0];
  assign enter_load  = !busy && pending_q;
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == (PW+1)'(FIFO_DEPTH));
  // Pops are held for the whole load; pushes keep landing and may overflow.
  assign pop         = !busy && enable_q && !fifo_empty;
  assign push        = enable_q && adc_valid && (!fifo_full || pop);
  assign drop        = enable_q && adc_valid && fifo_full && !pop;
  assign unused_bits = ^{sys_addr[31:6], sys_addr[1:0], sys_wdata[31:16]};

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (reg_sel < 4'd9) begin
      rdata_d = {16'h0, coef_q[reg_sel]};
      err_d   = sys_wen && busy;
    end else if (reg_sel == 4'd9) begin
      rdata_d = {30'h0, enable_q, 1'b0};
    end else if (reg_sel == 4'd10) begin
      rdata_d = {8'h0, 8'(ovf_cnt_q), 8'(commit_cnt_q), 6'h0, pending_q, busy};
    end else begin
      err_d = 1'b1;
    end
    if (!(sys_wen || sys_ren)) err_d = 1'b0;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q      <= ST_STREAM;
      idx_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= 1'b0;
      enable_q     <= 1'b0;
      commit_cnt_q <= '0;
      ovf_cnt_q    <= '0;
      arg_q        <= '0;
      rdata_q      <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 9; i++) coef_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      ack_q     <= sys_wen || sys_ren;
      err_q     <= err_d;
      rdata_q   <= sys_ren ? rdata_d : '0;
      pending_q <= (pending_q && !enter_load) || commit_wr;
      arg_q     <= '0;

      if (sys_wen && (reg_sel < 4'd9) && !busy) coef_q[reg_sel] <= sys_wdata[15:0];
      if (sys_wen && (reg_sel == 4'd9)) enable_q <= sys_wdata[1];

      if (state_q == ST_LOAD) begin
        arg_q <= {2'b11, idx_q, coef_q[idx_q], 48'h0};
        idx_q <= idx_q + 4'd1;
        if (idx_q == 4'd8) begin
          state_q <= ST_STREAM;
          if (commit_cnt_q != '1) commit_cnt_q <= commit_cnt_q + CNT_W'(1);
        end
      end else begin
        if (pop) arg_q <= {2'b10, 20'h0, fifo_q[rd_ptr_q]};
        if (pending_q) begin
          state_q <= ST_LOAD;
          idx_q   <= '0;
        end
      end

      // Disabling the stream empties the buffer and ignores arrivals without counting them.
      if (!enable_q) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= {adc_c, adc_b, adc_a};
          wr_ptr_q         <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        if (drop && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
      end
    end
  end

  assign arg       = arg_q;
  assign sys_rdata = rdata_q;
  assign sys_ack   = ack_q;
  assign sys_err   = err_q;

endmodule

// File: tb/tb_matrix_multiply_core3x3_feeder.sv
// tb/tb_matrix_multiply_core3x3_feeder.sv - self-checking bench for matrix_multiply_core3x3_feeder
// Directed scenarios plus a randomized run against a queue-based transaction model.
module tb_matrix_multiply_core3x3_feeder;

  localparam int DEPTH = 4;

  logic        system1000, system1000_rstn;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic        sys_wen, sys_ren, sys_ack, sys_err;
  logic [15:0] adc_a, adc_b, adc_c;
  logic        adc_valid;
  logic [69:0] arg;

  int n_tests = 0;
  int n_fail  = 0;

  matrix_multiply_core3x3_feeder #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .system1000(system1000), .system1000_rstn(system1000_rstn),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err),
    .adc_a(adc_a), .adc_b(adc_b), .adc_c(adc_c), .adc_valid(adc_valid), .arg(arg)
  );

  initial system1000 = 1'b0;
  always #5 system1000 = ~system1000;

  // Reference model: coefficient array, sample queue, remaining-load bookkeeping.
  logic [15:0] m_coef [9];
  logic [47:0] m_fifo [$];
  bit          m_loading, m_pending, m_enable;
  logic [3:0]  m_idx;
  int          m_ccnt, m_ocnt;
  logic [69:0] e_arg;
  logic [31:0] e_rdata;
  logic        e_ack, e_err;

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_coef[i] = '0;
    m_fifo.delete();
    m_loading = 0; m_pending = 0; m_enable = 0; m_idx = '0;
    m_ccnt = 0; m_ocnt = 0;
    e_arg = '0; e_rdata = '0; e_ack = 0; e_err = 0;
  endtask

  task automatic model_step();
    int a = int'(sys_addr[5:2]);
    bit was_loading = m_loading;
    bit en_prev = m_enable;
    logic [47:0] smp = {adc_c, adc_b, adc_a};
    e_arg = '0; e_rdata = '0; e_err = 0; e_ack = sys_wen || sys_ren;
    if (sys_ren) begin
      if (a < 9) e_rdata = {16'h0, m_coef[a]};
      else if (a == 9) e_rdata = {30'h0, m_enable, 1'b0};
      else if (a == 10) e_rdata = {8'h0, 8'(m_ocnt), 8'(m_ccnt), 6'h0, m_pending, m_loading};
      else e_err = 1;
    end
    if (was_loading) begin
      e_arg = {2'b11, m_idx, m_coef[m_idx], 48'h0};
      if (m_idx == 4'd8) begin
        m_loading = 0;
        if (m_ccnt < 255) m_ccnt++;
      end else m_idx++;
    end else begin
      if (en_prev && m_fifo.size() > 0) e_arg = {2'b10, 20'h0, m_fifo.pop_front()};
      if (m_pending) begin m_loading = 1; m_idx = '0; m_pending = 0; end
    end
    if (!en_prev) m_fifo.delete();
    else if (adc_valid) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(smp);
      else if (m_ocnt < 255) m_ocnt++;
    end
    if (sys_wen) begin
      if (a < 9) begin
        if (was_loading) e_err = 1; else m_coef[a] = sys_wdata[15:0];
      end else if (a == 9) begin
        m_enable = sys_wdata[1];
        if (sys_wdata[0]) m_pending = 1;
      end else if (a > 10) e_err = 1;
    end
  endtask

  task automatic tick();
    @(posedge system1000);
    model_step();
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    sys_addr = addr; sys_wdata = data; sys_wen = 1'b1;
    tick();
    sys_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr);
    sys_addr = addr; sys_ren = 1'b1;
    tick();
    sys_ren = 1'b0;
  endtask

  task automatic apply_reset();
    system1000_rstn = 1'b0;
    sys_wen = 0; sys_ren = 0; sys_addr = '0; sys_wdata = '0;
    adc_valid = 0; adc_a = '0; adc_b = '0; adc_c = '0;
    model_reset();
    repeat (2) @(posedge system1000);
    #1 system1000_rstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (arg !== 70'h0) begin n_fail++; $display("FAIL reset_arg got %h want 0", arg); end
    bus_read(32'h28);
    n_tests++;
    if (sys_ack !== 1'b1 || sys_err !== 1'b0 || sys_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_status ack=%b err=%b rdata=%h want 1 0 0", sys_ack, sys_err, sys_rdata);
    end
    bus_read(32'h3C);
    n_tests++;
    if (sys_ack !== 1'b1 || sys_err !== 1'b1 || sys_rdata !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read ack=%b err=%b rdata=%h want 1 1 0", sys_ack, sys_err, sys_rdata);
    end
    tick();
    n_tests++;
    if (sys_ack !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle got %b want 0", sys_ack); end
  endtask

  task automatic test_commit();
    int waited = 0;
    for (int i = 0; i < 9; i++) bus_write(32'(i * 4), 32'(i + 1));
    bus_write(32'h24, 32'h1);
    while (arg[69] !== 1'b1 && waited < 5) begin tick(); waited++; end
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (arg !== {2'b11, 4'(i), 16'(i + 1), 48'h0}) begin
        n_fail++; $display("FAIL coef_word_%0d got %h want %h", i, arg, {2'b11, 4'(i), 16'(i + 1), 48'h0});
      end
      tick();
    end
    bus_read(32'h28);
    n_tests++;
    if (sys_rdata[15:8] !== 8'd1 || sys_rdata[0] !== 1'b0) begin
      n_fail++; $display("FAIL commit_count status=%h want count 1 idle", sys_rdata);
    end
  endtask

  task automatic test_sample();
    bus_write(32'h24, 32'h2);
    adc_a = 16'h0001; adc_b = 16'hFFFE; adc_c = 16'h0003; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    n_tests++;
    if (arg[69] !== 1'b0) begin n_fail++; $display("FAIL sample_no_bypass got %h want valid 0", arg); end
    tick();
    n_tests++;
    if (arg !== {2'b10, 20'h0, 16'h3, 16'hFFFE, 16'h1}) begin
      n_fail++; $display("FAIL sample_word got %h want %h", arg, {2'b10, 20'h0, 16'h3, 16'hFFFE, 16'h1});
    end
  endtask

  task automatic test_overflow();
    logic [47:0] sent [$];
    logic [47:0] s;
    bus_write(32'h24, 32'h3);
    tick();
    for (int i = 0; i < 9; i++) begin
      adc_a = 16'($urandom); adc_b = 16'($urandom); adc_c = 16'($urandom); adc_valid = 1'b1;
      sent.push_back({adc_c, adc_b, adc_a});
      tick();
      n_tests++;
      if (arg[69:64] !== {2'b11, 4'(i)}) begin
        n_fail++; $display("FAIL ovf_load_word_%0d got %h want hdr %h", i, arg[69:64], {2'b11, 4'(i)});
      end
    end
    adc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      s = sent[i];
      n_tests++;
      if (arg !== {2'b10, 20'h0, s}) begin
        n_fail++; $display("FAIL drain_%0d got %h want %h", i, arg, {2'b10, 20'h0, s});
      end
    end
    tick();
    n_tests++;
    if (arg[69] !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %h want valid 0", arg); end
    bus_read(32'h28);
    n_tests++;
    if (sys_rdata[23:16] !== 8'd5 || sys_rdata[15:8] !== 8'd2) begin
      n_fail++; $display("FAIL overflow_count status=%h want ovf 5 commits 2", sys_rdata);
    end
  endtask

  task automatic test_load_collisions();
    int words = 0;
    bus_write(32'h24, 32'h3);
    tick();
    bus_write(32'h00, 32'hBEEF);
    n_tests++;
    if (sys_ack !== 1'b1 || sys_err !== 1'b1) begin
      n_fail++; $display("FAIL coef_write_busy ack=%b err=%b want 1 1", sys_ack, sys_err);
    end
    if (arg[69:68] == 2'b11) words++;
    bus_write(32'h24, 32'h3);
    if (arg[69:68] == 2'b11) words++;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (arg[69:68] == 2'b11) words++;
    end
    n_tests++;
    if (words != 18) begin n_fail++; $display("FAIL double_load_words got %0d want 18", words); end
    bus_read(32'h00);
    n_tests++;
    if (sys_rdata !== 32'h1 || sys_err !== 1'b0) begin
      n_fail++; $display("FAIL coef0_unchanged got %h err=%b want 1 0", sys_rdata, sys_err);
    end
    bus_read(32'h28);
    n_tests++;
    if (sys_rdata[15:8] !== 8'd4) begin n_fail++; $display("FAIL commit_count4 got %0d want 4", sys_rdata[15:8]); end
  endtask

  task automatic test_reset_mid_load();
    int waited = 0;
    bus_write(32'h24, 32'h1);
    while (!(arg[69:68] === 2'b11 && arg[67:64] === 4'd4) && waited < 15) begin tick(); waited++; end
    n_tests++;
    if (waited >= 15) begin n_fail++; $display("FAIL reach_idx4 timeout got %h want idx 4", arg); end
    #2 system1000_rstn = 1'b0;
    #1;
    n_tests++;
    if (arg !== 70'h0 || sys_ack !== 1'b0) begin
      n_fail++; $display("FAIL async_reset arg=%h ack=%b want 0 0", arg, sys_ack);
    end
    model_reset();
    repeat (2) @(posedge system1000);
    #1 system1000_rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_tests++;
      if (arg[69] !== 1'b0) begin n_fail++; $display("FAIL no_resume cycle %0d got %h want 0", c, arg); end
    end
    bus_read(32'h28);
    n_tests++;
    if (sys_rdata !== 32'h0) begin n_fail++; $display("FAIL post_reset_status got %h want 0", sys_rdata); end
    bus_read(32'h0C);
    n_tests++;
    if (sys_rdata !== 32'h0) begin n_fail++; $display("FAIL post_reset_coef got %h want 0", sys_rdata); end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      sys_wen = 0; sys_ren = 0;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        sys_wen = 1; sys_addr = 32'h24;
        sys_wdata = {30'h0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0)};
      end else if (r < 16) begin
        sys_wen = 1; sys_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00}; sys_wdata = $urandom;
        if (sys_addr[5:2] == 4'd9) sys_wdata[1] = 1'b1;
      end else if (r < 30) begin
        sys_ren = 1; sys_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      end
      adc_valid = ($urandom_range(0, 9) < 7);
      adc_a = 16'($urandom); adc_b = 16'($urandom); adc_c = 16'($urandom);
      tick();
      n_tests++;
      if (arg !== e_arg) begin n_fail++; $display("FAIL rand_arg cyc %0d got %h want %h", c, arg, e_arg); end
      n_tests++;
      if (sys_ack !== e_ack || sys_err !== e_err || sys_rdata !== e_rdata) begin
        n_fail++;
        $display("FAIL rand_bus cyc %0d got ack=%b err=%b rdata=%h want %b %b %h",
                 c, sys_ack, sys_err, sys_rdata, e_ack, e_err, e_rdata);
      end
    end
    sys_wen = 0; sys_ren = 0; adc_valid = 0;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_sample();
    test_overflow();
    test_load_collisions();
    test_reset_mid_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
